// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch memory responder.
package inst_mem_responder_pkg;

    localparam int IM_WIDTH    = 64;
    localparam int IM_IDX_BITS = 4;

    typedef enum logic {
        IM_IDLE = 1'b0,
        IM_REQ  = 1'b1
    } im_state_e;

endpackage

// File: rtl/inst_mem_responder_cache_array.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Reads are combinational; there is one write port and a flush-all input.
module inst_mem_responder_cache_array
    import inst_mem_responder_pkg::*;
#(
    parameter int IDX_BITS = IM_IDX_BITS,
    parameter int TAG_BITS = IM_WIDTH - 2 - IM_IDX_BITS
) (
    input  logic                p_clk,
    input  logic                p_rst_l,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data,
    input  logic                flush
);

    localparam int NLINES = 2 ** IDX_BITS;

    logic [NLINES-1:0]   valid_q;
    logic [TAG_BITS-1:0] tag_q  [NLINES];
    logic [31:0]         data_q [NLINES];

    // Flush wins over a same-cycle fill so the filled line ends invalid.
    always_ff @(posedge p_clk or negedge p_rst_l) begin
        if (!p_rst_l) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge p_clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_mem_responder.sv
// Responder end of the instruction-fetch interface: zero-latency hits,
// miss refill over a req/ack bus, saturating miss counter.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int WIDTH    = IM_WIDTH,
    parameter int IDX_BITS = IM_IDX_BITS
) (
    input  logic             p_clk,
    input  logic             p_rst_l,
    input  logic [WIDTH-1:0] p_IM_Address,
    input  logic             p_IM_Read,
    output logic [31:0]      p_IM_DataOut,
    output logic             p_IM_Wait,
    input  logic             p_IM_Flush,
    output logic             p_IM_BusReq,
    output logic [WIDTH-1:0] p_IM_BusAddr,
    input  logic [31:0]      p_IM_BusData,
    input  logic             p_IM_BusAck,
    output logic [31:0]      p_IM_MissCount
);

    localparam int               TAG_BITS   = WIDTH - 2 - IDX_BITS;
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    im_state_e           state_q;
    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0] rd_tag_req;
    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;
    logic [31:0]         line_data;
    logic                hit;
    logic                fill_en;

    assign rd_idx     = p_IM_Address[IDX_BITS+1:2];
    assign rd_tag_req = p_IM_Address[WIDTH-1:IDX_BITS+2];
    assign hit        = p_IM_Read & line_valid & (line_tag == rd_tag_req);
    assign fill_en    = (state_q == IM_REQ) & p_IM_BusAck;

    inst_mem_responder_cache_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_cache (
        .p_clk    (p_clk),
        .p_rst_l  (p_rst_l),
        .rd_idx   (rd_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill_en),
        .wr_idx   (p_IM_BusAddr[IDX_BITS+1:2]),
        .wr_tag   (p_IM_BusAddr[WIDTH-1:IDX_BITS+2]),
        .wr_data  (p_IM_BusData),
        .flush    (p_IM_Flush)
    );

    always_comb begin
        p_IM_Wait    = p_IM_Read & ((state_q == IM_REQ) | ~hit);
        p_IM_DataOut = ((state_q == IM_IDLE) && hit) ? line_data : 32'd0;
    end

    // The registered bus address doubles as the latched miss address.
    always_ff @(posedge p_clk or negedge p_rst_l) begin
        if (!p_rst_l) begin
            state_q        <= IM_IDLE;
            p_IM_BusReq    <= 1'b0;
            p_IM_BusAddr   <= '0;
            p_IM_MissCount <= 32'd0;
        end else begin
            case (state_q)
                IM_IDLE: begin
                    if (p_IM_Read && !hit) begin
                        state_q      <= IM_REQ;
                        p_IM_BusReq  <= 1'b1;
                        p_IM_BusAddr <= p_IM_Address & ALIGN_MASK;
                        if (p_IM_MissCount != 32'hFFFF_FFFF) begin
                            p_IM_MissCount <= p_IM_MissCount + 32'd1;
                        end
                    end
                end
                IM_REQ: begin
                    if (p_IM_BusAck) begin
                        state_q     <= IM_IDLE;
                        p_IM_BusReq <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IM_IDLE;
                    p_IM_BusReq <= 1'b0;
                end
            endcase
        end
    end

endmodule
